// File: rtl/alu_pkg.sv
// Shared encodings for the ALU operand selector: transform modes and skid states.
package alu_pkg;

    typedef logic [1:0] opsel_mode_t;

    localparam opsel_mode_t OPSEL_PASS = 2'd0;
    localparam opsel_mode_t OPSEL_NOT  = 2'd1;
    localparam opsel_mode_t OPSEL_NEG  = 2'd2;
    localparam opsel_mode_t OPSEL_ZERO = 2'd3;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_t;

endpackage

// File: rtl/alu_opsel_skid.sv
// Two-entry valid/ready skid register. Both in_ready and out_valid come straight
// from flops, so no combinational path runs from out_ready to in_ready.
module alu_opsel_skid
    import alu_pkg::*;
#(
    parameter int unsigned DW = 33
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    skid_state_t   state_q;
    logic          in_ready_q;
    logic          out_valid_q;
    logic [DW-1:0] out_q;
    logic [DW-1:0] skid_q;

    logic accept;
    logic retire;

    assign accept = in_valid && in_ready_q;
    assign retire = out_valid_q && out_ready;

    // Occupancy FSM with output and skid data registers; reset flushes everything.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= SKID_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            skid_q      <= '0;
        end else begin
            case (state_q)
                SKID_EMPTY: begin
                    if (accept) begin
                        out_q       <= in_data;
                        out_valid_q <= 1'b1;
                        state_q     <= SKID_ONE;
                    end
                end
                SKID_ONE: begin
                    if (accept && !retire) begin
                        skid_q     <= in_data;
                        in_ready_q <= 1'b0;
                        state_q    <= SKID_TWO;
                    end else if (accept) begin
                        out_q <= in_data;
                    end else if (retire) begin
                        out_valid_q <= 1'b0;
                        state_q     <= SKID_EMPTY;
                    end
                end
                SKID_TWO: begin
                    if (retire) begin
                        out_q      <= skid_q;
                        in_ready_q <= 1'b1;
                        state_q    <= SKID_ONE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= SKID_EMPTY;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_q;

endmodule

// File: rtl/alu_operand_sel.sv
// ALU operand selector: picks one of NUM_IN sources, applies pass/NOT/negate/zero,
// and registers the result behind a two-entry skid buffer.
// Optional: define ALU_OPSEL_PARITY_EN to add the out_parity output.
module alu_operand_sel
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SEL_W-1:0]        sel,
    input  opsel_mode_t             mode,
    input  logic [NUM_IN*WIDTH-1:0] data_in,
    output logic                    out_valid,
    input  logic                    out_ready,
`ifdef ALU_OPSEL_PARITY_EN
    output logic                    out_parity,
`endif
    output logic [WIDTH-1:0]        data_out,
    output logic                    sel_err
);

`ifdef ALU_OPSEL_PARITY_EN
    localparam int unsigned PAR_W = 1;
`else
    localparam int unsigned PAR_W = 0;
`endif
    localparam int unsigned DW = WIDTH + 1 + PAR_W;

    logic [WIDTH-1:0] src_c;
    logic [WIDTH-1:0] xf_c;
    logic             err_c;
    logic [DW-1:0]    pay_in;
    logic [DW-1:0]    pay_out;

    // Source mux; an out-of-range index selects zero.
    always_comb begin
        src_c = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (SEL_W'(i) == sel) begin
                src_c = data_in[i*WIDTH +: WIDTH];
            end
        end
    end

    // Transform and error flag; zero mode masks the range error.
    always_comb begin
        xf_c = '0;
        case (mode)
            OPSEL_PASS: xf_c = src_c;
            OPSEL_NOT:  xf_c = ~src_c;
            OPSEL_NEG:  xf_c = ~src_c + WIDTH'(1);
            default:    xf_c = '0;
        endcase
        err_c = (32'(sel) >= NUM_IN) && (mode != OPSEL_ZERO);
    end

`ifdef ALU_OPSEL_PARITY_EN
    assign pay_in = {^xf_c, err_c, xf_c};
`else
    assign pay_in = {err_c, xf_c};
`endif

    alu_opsel_skid #(
        .DW(DW)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (pay_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (pay_out)
    );

`ifdef ALU_OPSEL_PARITY_EN
    assign {out_parity, sel_err, data_out} = pay_out;
`else
    assign {sel_err, data_out} = pay_out;
`endif

endmodule
